// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, fetches one instruction at a time and steers the next PC.
// Optional macro MISALIGN_TRAP_EN adds a sticky trap and HALT state on misaligned targets.
module instruction_fetch_unit #(
    parameter int              WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter int              CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             imem_req_valid,
    input  logic             imem_req_ready,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_rsp_valid,
    input  logic [WIDTH-1:0] imem_rsp_data,
    output logic [WIDTH-1:0] instruction,
    output logic             instr_valid,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus4,
    input  logic             advance,
    input  logic             mux_pc_signal,
    input  logic             mux_jalr,
    input  logic [WIDTH-1:0] imm,
    input  logic [WIDTH-1:0] rs1_data,
    output logic [CNT_W-1:0] instret,
    output logic             trap
);

    localparam logic [WIDTH-1:0] NOP_INSTR = WIDTH'(32'h0000_0013);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
`ifdef MISALIGN_TRAP_EN
        S_EXEC  = 2'd2,
        S_HALT  = 2'd3
`else
        S_EXEC  = 2'd2
`endif
    } state_t;

    state_t           r_state;
    state_t           r_state_next;
    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_instr;
    logic             r_instr_valid;
    logic [CNT_W-1:0] r_instret;

    logic             w_req_valid;
    logic             w_load_instr;
    logic             w_retire;
    logic             w_trap_set;
    logic [WIDTH-1:0] w_pc_plus4;
    logic [WIDTH-1:0] w_branch_target;
    logic [WIDTH-1:0] w_jalr_sum;
    logic [WIDTH-1:0] w_jalr_target;
    logic [WIDTH-1:0] w_next_pc;

    // All PC arithmetic wraps naturally at 2^WIDTH.
    assign w_pc_plus4      = r_pc + WIDTH'(4);
    assign w_branch_target = r_pc + imm;
    assign w_jalr_sum      = rs1_data + imm;
    assign w_jalr_target   = w_jalr_sum & ~WIDTH'(1);
    assign w_next_pc       = mux_jalr      ? w_jalr_target   :
                             mux_pc_signal ? w_branch_target :
                                             w_pc_plus4;

    always_comb begin
        r_state_next = r_state;
        w_req_valid  = 1'b0;
        w_load_instr = 1'b0;
        w_retire     = 1'b0;
        w_trap_set   = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_req_valid = 1'b1;
                if (imem_req_ready) begin
                    r_state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    w_load_instr = 1'b1;
                    r_state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                if (advance) begin
                    w_retire     = 1'b1;
                    r_state_next = S_FETCH;
`ifdef MISALIGN_TRAP_EN
                    if (w_next_pc[1:0] != 2'b00) begin
                        w_trap_set   = 1'b1;
                        r_state_next = S_HALT;
                    end
`endif
                end
            end
`ifdef MISALIGN_TRAP_EN
            S_HALT: begin
                r_state_next = S_HALT;
            end
`endif
            default: begin
                r_state_next = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= S_FETCH;
            r_pc          <= RESET_PC;
            r_instr       <= NOP_INSTR;
            r_instr_valid <= 1'b0;
            r_instret     <= '0;
        end else begin
            r_state <= r_state_next;
            if (w_load_instr) begin
                r_instr       <= imem_rsp_data;
                r_instr_valid <= 1'b1;
            end
            // A faulting instruction still retires, but the PC stays on it.
            if (w_retire) begin
                r_instret     <= r_instret + CNT_W'(1);
                r_instr_valid <= 1'b0;
                if (!w_trap_set) begin
                    r_pc <= w_next_pc;
                end
            end
        end
    end

`ifdef MISALIGN_TRAP_EN
    logic r_trap;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_trap <= 1'b0;
        end else if (w_trap_set) begin
            r_trap <= 1'b1;
        end
    end

    assign trap = r_trap;
`else
    assign trap = 1'b0;
`endif

    // Request is squashed combinationally while reset is held.
    assign imem_req_valid = w_req_valid & rst_n;
    assign imem_addr      = r_pc;
    assign instruction    = r_instr;
    assign instr_valid    = r_instr_valid;
    assign pc             = r_pc;
    assign pc_plus4       = w_pc_plus4;
    assign instret        = r_instret;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: scoreboarded fetch addresses and
// instruction words, steering, backpressure, wrap, reset abort and misalign handling.
module tb_instruction_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic [31:0] instruction;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        advance;
    logic        mux_pc_signal;
    logic        mux_jalr;
    logic [31:0] imm;
    logic [31:0] rs1_data;
    logic [31:0] instret;
    logic        trap;

    instruction_fetch_unit #(
        .WIDTH    (32),
        .RESET_PC (32'h0000_0000),
        .CNT_W    (32)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instruction    (instruction),
        .instr_valid    (instr_valid),
        .pc             (pc),
        .pc_plus4       (pc_plus4),
        .advance        (advance),
        .mux_pc_signal  (mux_pc_signal),
        .mux_jalr       (mux_jalr),
        .imm            (imm),
        .rs1_data       (rs1_data),
        .instret        (instret),
        .trap           (trap)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] instr;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks;
    int          n_pass;
    logic [31:0] exp_instret;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drives one full fetch/response/advance transaction and reports what was observed.
    task automatic run_instr(
        input  logic [31:0] data,
        input  int          rdy_wait,
        input  int          rsp_wait,
        input  logic        jalr_v,
        input  logic        br_v,
        input  logic [31:0] imm_v,
        input  logic [31:0] rs1_v,
        output logic [31:0] addr_seen,
        output logic [31:0] instr_seen,
        output logic [31:0] pc_seen,
        output logic [31:0] pc4_seen,
        output int          cycles,
        output bit          stable,
        output bit          early,
        output bit          tmo
    );
        addr_seen  = 'x;
        instr_seen = 'x;
        pc_seen    = 'x;
        pc4_seen   = 'x;
        cycles     = 0;
        stable     = 1'b1;
        early      = 1'b0;
        tmo        = 1'b0;
        for (int i = 0; i < 20 && imem_req_valid !== 1'b1; i++) begin
            @(posedge clk); #1;
        end
        if (imem_req_valid !== 1'b1) begin
            tmo = 1'b1;
            return;
        end
        addr_seen = imem_addr;
        for (int i = 0; i < rdy_wait; i++) begin
            imem_req_ready = 1'b0;
            @(posedge clk); #1;
            cycles++;
            if (imem_addr !== addr_seen || imem_req_valid !== 1'b1) stable = 1'b0;
            if (instr_valid !== 1'b0) early = 1'b1;
        end
        imem_req_ready = 1'b1;
        @(posedge clk); #1;
        cycles++;
        imem_req_ready = 1'b0;
        for (int i = 0; i < rsp_wait; i++) begin
            @(posedge clk); #1;
            cycles++;
            if (instr_valid !== 1'b0) early = 1'b1;
            if (imem_req_valid !== 1'b0) stable = 1'b0;
        end
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = data;
        @(posedge clk); #1;
        cycles++;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'hA5A5_5A5A;
        if (instr_valid === 1'b1) instr_seen = instruction;
        pc_seen        = pc;
        pc4_seen       = pc_plus4;
        mux_jalr       = jalr_v;
        mux_pc_signal  = br_v;
        imm            = imm_v;
        rs1_data       = rs1_v;
        advance        = 1'b1;
        @(posedge clk); #1;
        cycles++;
        advance        = 1'b0;
        mux_jalr       = 1'b0;
        mux_pc_signal  = 1'b0;
        imm            = 32'h0;
        rs1_data       = 32'h0;
        exp_instret    = exp_instret + 32'd1;
    endtask

    task automatic test_reset();
        rst_n          = 1'b0;
        advance        = 1'b1;
        imem_rsp_valid = 1'b1;
        imem_req_ready = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (instr_valid !== 1'b0) $display("FAIL rst_valid got %b exp 0", instr_valid); else n_pass++;
        n_checks++; if (pc !== 32'h0) $display("FAIL rst_pc got %h exp 00000000", pc); else n_pass++;
        n_checks++; if (imem_req_valid !== 1'b0) $display("FAIL rst_req got %b exp 0", imem_req_valid); else n_pass++;
        n_checks++; if (instret !== 32'h0) $display("FAIL rst_instret got %0d exp 0", instret); else n_pass++;
        n_checks++; if (instruction !== 32'h0000_0013) $display("FAIL rst_instr got %h exp 00000013", instruction); else n_pass++;
        n_checks++; if (trap !== 1'b0) $display("FAIL rst_trap got %b exp 0", trap); else n_pass++;
        rst_n          = 1'b1;
        advance        = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_req_ready = 1'b0;
        exp_instret    = 32'h0;
        @(posedge clk); #1;
        n_checks++; if (imem_req_valid !== 1'b1) $display("FAIL rel_req got %b exp 1", imem_req_valid); else n_pass++;
        n_checks++; if (imem_addr !== 32'h0) $display("FAIL rel_addr got %h exp 00000000", imem_addr); else n_pass++;
        $display("reset: req_valid=%b addr=%h instret=%0d", imem_req_valid, imem_addr, instret);
    endtask

    task automatic test_sequential();
        logic [31:0] a, ins, p, p4;
        int cyc;
        bit st, er, to;
        exp_t e;
        exp_q.push_back('{addr: 32'h0, instr: 32'h0062_8233});
        run_instr(32'h0062_8233, 0, 0, 1'b0, 1'b0, 32'h0, 32'h0, a, ins, p, p4, cyc, st, er, to);
        e = exp_q.pop_front();
        n_checks++; if (to) $display("FAIL seq_timeout no request seen"); else n_pass++;
        n_checks++; if (a !== e.addr) $display("FAIL seq_addr got %h exp %h", a, e.addr); else n_pass++;
        n_checks++; if (ins !== e.instr) $display("FAIL seq_instr got %h exp %h", ins, e.instr); else n_pass++;
        n_checks++; if (p4 !== 32'h4) $display("FAIL seq_pc4 got %h exp 00000004", p4); else n_pass++;
        n_checks++; if (cyc != 3) $display("FAIL seq_cycles got %0d exp 3", cyc); else n_pass++;
        n_checks++; if (instret !== 32'd1) $display("FAIL seq_instret got %0d exp 1", instret); else n_pass++;
        $display("seq: addr=%h instr=%h cycles=%0d instret=%0d", a, ins, cyc, instret);
        exp_q.push_back('{addr: 32'h4, instr: 32'h0000_0013});
        run_instr(32'h0000_0013, 0, 0, 1'b0, 1'b0, 32'h0, 32'h0, a, ins, p, p4, cyc, st, er, to);
        e = exp_q.pop_front();
        n_checks++; if (a !== e.addr) $display("FAIL seq2_addr got %h exp %h", a, e.addr); else n_pass++;
        n_checks++; if (p !== 32'h4) $display("FAIL seq2_pc got %h exp 00000004", p); else n_pass++;
        $display("seq: addr=%h instr=%h cycles=%0d instret=%0d", a, ins, cyc, instret);
    endtask

    task automatic test_branch();
        logic [31:0] a, ins, p, p4;
        int cyc;
        bit st, er, to;
        exp_t e;
        // taken branch at 0x8, +16
        exp_q.push_back('{addr: 32'h8, instr: 32'h0000_8863});
        run_instr(32'h0000_8863, 0, 0, 1'b0, 1'b1, 32'd16, 32'h0, a, ins, p, p4, cyc, st, er, to);
        e = exp_q.pop_front();
        n_checks++; if (a !== e.addr || ins !== e.instr) $display("FAIL br_taken_src got %h/%h exp %h/%h", a, ins, e.addr, e.instr); else n_pass++;
        // jalr back to 0x8 from the branch target
        exp_q.push_back('{addr: 32'h18, instr: 32'h0000_8067});
        run_instr(32'h0000_8067, 0, 0, 1'b1, 1'b0, 32'h0, 32'h8, a, ins, p, p4, cyc, st, er, to);
        e = exp_q.pop_front();
        n_checks++; if (a !== e.addr || ins !== e.instr) $display("FAIL br_taken_dst got %h/%h exp %h/%h", a, ins, e.addr, e.instr); else n_pass++;
        // not-taken branch at 0x8 with the same immediate
        exp_q.push_back('{addr: 32'h8, instr: 32'h0000_8863});
        run_instr(32'h0000_8863, 0, 0, 1'b0, 1'b0, 32'd16, 32'h0, a, ins, p, p4, cyc, st, er, to);
        e = exp_q.pop_front();
        n_checks++; if (a !== e.addr) $display("FAIL br_nt_src got %h exp %h", a, e.addr); else n_pass++;
        $display("branch: taken ->18, back ->8, not-taken from %h instret=%0d", a, instret);
    endtask

    task automatic test_jalr();
        logic [31:0] a, ins, p, p4;
        int cyc;
        bit st, er, to;
        exp_t e;
        exp_q.push_back('{addr: 32'hC, instr: 32'h0200_80E7});
        run_instr(32'h0200_80E7, 0, 0, 1'b1, 1'b1, 32'h20, 32'h101, a, ins, p, p4, cyc, st, er, to);
        e = exp_q.pop_front();
        n_checks++; if (a !== e.addr) $display("FAIL jalr_src got %h exp %h", a, e.addr); else n_pass++;
        n_checks++; if (p4 !== 32'h10) $display("FAIL jalr_pc4 got %h exp 00000010", p4); else n_pass++;
        n_checks++; if (imem_addr !== 32'h120 || imem_req_valid !== 1'b1) $display("FAIL jalr_target got %h/%b exp 00000120/1", imem_addr, imem_req_valid); else n_pass++;
        $display("jalr: from %h pc_plus4=%h target=%h", a, p4, imem_addr);
    endtask

    task automatic test_backpressure_wrap();
        logic [31:0] a, ins, p, p4;
        int cyc;
        bit st, er, to;
        exp_t e;
        exp_q.push_back('{addr: 32'h120, instr: 32'h0041_0113});
        run_instr(32'h0041_0113, 3, 2, 1'b1, 1'b0, 32'hC, 32'hFFFF_FFF0, a, ins, p, p4, cyc, st, er, to);
        e = exp_q.pop_front();
        n_checks++; if (a !== e.addr || ins !== e.instr) $display("FAIL bp_xfer got %h/%h exp %h/%h", a, ins, e.addr, e.instr); else n_pass++;
        n_checks++; if (!st) $display("FAIL bp_stable got unstable exp stable addr/req"); else n_pass++;
        n_checks++; if (er) $display("FAIL bp_early got instr_valid=1 exp 0 before rsp"); else n_pass++;
        n_checks++; if (cyc != 8) $display("FAIL bp_cycles got %0d exp 8", cyc); else n_pass++;
        $display("backpressure: addr=%h instr=%h cycles=%0d", a, ins, cyc);
        exp_q.push_back('{addr: 32'hFFFF_FFFC, instr: 32'h0000_0013});
        run_instr(32'h0000_0013, 0, 0, 1'b0, 1'b0, 32'h0, 32'h0, a, ins, p, p4, cyc, st, er, to);
        e = exp_q.pop_front();
        n_checks++; if (a !== e.addr) $display("FAIL wrap_src got %h exp %h", a, e.addr); else n_pass++;
        n_checks++; if (p4 !== 32'h0) $display("FAIL wrap_pc4 got %h exp 00000000", p4); else n_pass++;
        n_checks++; if (imem_addr !== 32'h0) $display("FAIL wrap_addr got %h exp 00000000", imem_addr); else n_pass++;
        n_checks++; if (instret !== exp_instret) $display("FAIL wrap_instret got %0d exp %0d", instret, exp_instret); else n_pass++;
        $display("wrap: from %h next addr=%h instret=%0d", a, imem_addr, instret);
    endtask

    task automatic test_misalign();
        logic [31:0] a, ins, p, p4;
        int cyc;
        bit st, er, to;
        bit saw_req;
        exp_t e;
        exp_q.push_back('{addr: 32'h0, instr: 32'h0060_006F});
        run_instr(32'h0060_006F, 0, 0, 1'b0, 1'b1, 32'h6, 32'h0, a, ins, p, p4, cyc, st, er, to);
        e = exp_q.pop_front();
        n_checks++; if (a !== e.addr || ins !== e.instr) $display("FAIL mis_src got %h/%h exp %h/%h", a, ins, e.addr, e.instr); else n_pass++;
        n_checks++; if (instret !== exp_instret) $display("FAIL mis_instret got %0d exp %0d", instret, exp_instret); else n_pass++;
`ifdef MISALIGN_TRAP_EN
        n_checks++; if (trap !== 1'b1) $display("FAIL mis_trap got %b exp 1", trap); else n_pass++;
        n_checks++; if (pc !== 32'h0 || instr_valid !== 1'b0) $display("FAIL mis_halt got pc=%h v=%b exp 0/0", pc, instr_valid); else n_pass++;
        saw_req = 1'b0;
        imem_rsp_valid = 1'b1;
        advance        = 1'b1;
        imem_req_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (imem_req_valid !== 1'b0) saw_req = 1'b1;
            @(posedge clk); #1;
        end
        imem_rsp_valid = 1'b0;
        advance        = 1'b0;
        imem_req_ready = 1'b0;
        n_checks++; if (saw_req) $display("FAIL mis_noreq got req_valid=1 exp 0 while halted"); else n_pass++;
        n_checks++; if (trap !== 1'b1) $display("FAIL mis_sticky got %b exp 1", trap); else n_pass++;
`else
        saw_req = imem_req_valid;
        n_checks++; if (trap !== 1'b0) $display("FAIL mis_trap got %b exp 0", trap); else n_pass++;
        n_checks++; if (saw_req !== 1'b1 || imem_addr !== 32'h6) $display("FAIL mis_addr got %h/%b exp 00000006/1", imem_addr, imem_req_valid); else n_pass++;
`endif
        $display("misalign: trap=%b pc=%h addr=%h instret=%0d", trap, pc, imem_addr, instret);
    endtask

    task automatic test_reset_mid();
        logic [31:0] a, ins, p, p4;
        int cyc;
        bit st, er, to;
        exp_t e;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_instret = 32'h0;
        #1;
        imem_req_ready = 1'b1;
        @(posedge clk); #1;
        imem_req_ready = 1'b0;
        rst_n          = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        n_checks++; if (instr_valid !== 1'b0 || instruction !== 32'h0000_0013) $display("FAIL mid_abort got %b/%h exp 0/00000013", instr_valid, instruction); else n_pass++;
        n_checks++; if (trap !== 1'b0 || instret !== 32'h0) $display("FAIL mid_clear got trap=%b instret=%0d exp 0/0", trap, instret); else n_pass++;
        imem_rsp_valid = 1'b0;
        rst_n          = 1'b1;
        #1;
        exp_q.push_back('{addr: 32'h0, instr: 32'h0010_0093});
        run_instr(32'h0010_0093, 0, 0, 1'b0, 1'b0, 32'h0, 32'h0, a, ins, p, p4, cyc, st, er, to);
        e = exp_q.pop_front();
        n_checks++; if (a !== e.addr || ins !== e.instr) $display("FAIL mid_refetch got %h/%h exp %h/%h", a, ins, e.addr, e.instr); else n_pass++;
        n_checks++; if (instret !== exp_instret) $display("FAIL mid_instret got %0d exp %0d", instret, exp_instret); else n_pass++;
        $display("reset_mid: refetch addr=%h instr=%h instret=%0d", a, ins, instret);
    endtask

    initial begin
        n_checks       = 0;
        n_pass         = 0;
        exp_instret    = 32'h0;
        rst_n          = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        advance        = 1'b0;
        mux_pc_signal  = 1'b0;
        mux_jalr       = 1'b0;
        imm            = 32'h0;
        rs1_data       = 32'h0;
        test_reset();
        test_sequential();
        test_branch();
        test_jalr();
        test_backpressure_wrap();
        test_misalign();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
